// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register load latency countdowns plus one
// outstanding MDU result; stalls on RAW and MDU structural conflicts.
module hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int LAT_W    = 3,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [4:0]        id_opcode,
   input  logic              id_funct3_lo,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_writes_rd,
   input  logic              id_is_load,
   input  logic              id_is_mdu,
   input  logic              flush,
   input  logic              mdu_done,
   output logic              hazard_stall,
   output logic [PERF_W-1:0] stall_count
);

   localparam int NREG = 2 ** REG_AW;
   localparam logic [LAT_W-1:0] LOAD_INIT = LAT_W'(LOAD_LAT);

   logic [LAT_W-1:0]  lat [NREG];
   logic              mdu_pend;
   logic [REG_AW-1:0] mdu_rd;

   logic uses_rs1;
   logic uses_rs2;
   logic rs1_busy;
   logic rs2_busy;
   logic raw_hz;
   logic struct_hz;
   logic issue;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (id_opcode)
         5'b11000, 5'b01000, 5'b01100: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         5'b11001, 5'b00000, 5'b00100: uses_rs1 = 1'b1;
         5'b11100:                     uses_rs1 = ~id_funct3_lo;
         default:                      ;
      endcase
   end

   // x0 is never a real producer, so reads of it are always free.
   assign rs1_busy = (id_rs1 != '0) &
                     ((lat[id_rs1] != '0) | (mdu_pend & (mdu_rd == id_rs1)));
   assign rs2_busy = (id_rs2 != '0) &
                     ((lat[id_rs2] != '0) | (mdu_pend & (mdu_rd == id_rs2)));

   assign raw_hz       = id_valid & ((uses_rs1 & rs1_busy) | (uses_rs2 & rs2_busy));
   assign struct_hz    = id_valid & id_is_mdu & mdu_pend;
   assign hazard_stall = (raw_hz | struct_hz) & ~flush;
   assign issue        = id_valid & ~hazard_stall & ~flush;

   // NOTE: the countdown array is reset in full; a reset must drop every pending producer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) lat[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (issue && id_writes_rd && (id_rd == REG_AW'(r)) && (r != 0))
               lat[r] <= id_is_load ? LOAD_INIT : '0;
            else if (lat[r] != '0)
               lat[r] <= lat[r] - LAT_W'(1);
         end
      end
   end

   // A start cannot meet a done: the structural stall blocks starts while pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mdu_pend <= 1'b0;
         mdu_rd   <= '0;
      end else if (issue && id_is_mdu) begin
         mdu_pend <= (id_rd != '0);
         mdu_rd   <= id_rd;
      end else if (mdu_done) begin
         mdu_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               stall_count <= '0;
      else if (hazard_stall) stall_count <= stall_count + PERF_W'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 instances on
// shared stimulus, checked against a ready-cycle reference model.
module tb_hazard_scoreboard;

   localparam int NR = 32;
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_IMM   = 5'b00100;
   localparam logic [4:0] OP_OP    = 5'b01100;
   localparam logic [4:0] OP_LUI   = 5'b01101;
   localparam logic [4:0] OP_AUIPC = 5'b00101;
   localparam logic [4:0] OP_BR    = 5'b11000;
   localparam logic [4:0] OP_JALR  = 5'b11001;
   localparam logic [4:0] OP_JAL   = 5'b11011;
   localparam logic [4:0] OP_SYS   = 5'b11100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [4:0]  id_opcode = '0;
   logic        id_funct3_lo = 1'b0;
   logic [4:0]  id_rs1 = '0;
   logic [4:0]  id_rs2 = '0;
   logic [4:0]  id_rd = '0;
   logic        id_writes_rd = 1'b0;
   logic        id_is_load = 1'b0;
   logic        id_is_mdu = 1'b0;
   logic        flush = 1'b0;
   logic        mdu_done = 1'b0;
   logic        stall_a, stall_b;
   logic [31:0] cnt_a, cnt_b;

   always #5 clk = ~clk;

   hazard_scoreboard #(.LOAD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_funct3_lo(id_funct3_lo), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
      .flush(flush), .mdu_done(mdu_done), .hazard_stall(stall_a), .stall_count(cnt_a)
   );

   hazard_scoreboard #(.LOAD_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_funct3_lo(id_funct3_lo), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
      .flush(flush), .mdu_done(mdu_done), .hazard_stall(stall_b), .stall_count(cnt_b)
   );

   typedef struct packed {
      logic        s0;
      logic        s1;
      logic [31:0] c0;
      logic [31:0] c1;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Reference model: a register is busy in every cycle up to and including ready[k][r].
   int          ready [2][NR];
   bit          mpend [2];
   int          mrd   [2];
   logic [31:0] mcnt  [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit src1(input logic [4:0] op, input logic f3);
      return (op inside {OP_BR, OP_JALR, OP_LOAD, OP_STORE, OP_IMM, OP_OP}) ||
             (op == OP_SYS && !f3);
   endfunction

   function automatic bit src2(input logic [4:0] op);
      return op inside {OP_BR, OP_STORE, OP_OP};
   endfunction

   function automatic bit busy(input int k, input logic [4:0] r);
      return (r != 0) && ((ready[k][r] >= cyc) || (mpend[k] && mrd[k] == int'(r)));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < NR; r++) ready[k][r] = -1;
         mpend[k] = 1'b0;
         mrd[k]   = 0;
         mcnt[k]  = '0;
      end
   endtask

   task automatic step(input bit v, input logic [4:0] op, input logic f3,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input bit mdu, input bit fl, input bit done, input bit r);
      exp_t e;
      bit   st [2];
      bit   wr, ld;
      @(posedge clk);
      #1;
      cyc++;
      wr = !(op inside {OP_BR, OP_STORE});
      ld = (op == OP_LOAD);
      id_valid = v; id_opcode = op; id_funct3_lo = f3;
      id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_writes_rd = wr; id_is_load = ld; id_is_mdu = mdu;
      flush = fl; mdu_done = done;
      rst = r;
      if (r) begin
         model_reset();
         q.push_back('0);
         return;
      end
      for (int k = 0; k < 2; k++) begin
         bit raw, iss;
         raw = v && ((src1(op, f3) && busy(k, r1)) || (src2(op) && busy(k, r2)));
         st[k] = !fl && (raw || (v && mdu && mpend[k]));
      end
      e.s0 = st[0]; e.s1 = st[1]; e.c0 = mcnt[0]; e.c1 = mcnt[1];
      q.push_back(e);
      for (int k = 0; k < 2; k++) begin
         bit iss;
         mcnt[k] = mcnt[k] + 32'(st[k]);
         iss = v && !st[k] && !fl;
         if (iss && wr && rd != 0) ready[k][rd] = ld ? cyc + (k == 1 ? 3 : 1) : cyc;
         if (iss && mdu) begin
            mpend[k] = (rd != 0);
            mrd[k]   = int'(rd);
         end else if (done) begin
            mpend[k] = 1'b0;
         end
      end
   endtask

   task automatic go(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd);
      step(1'b1, op, 1'b0, r1, r2, rd, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         check("stall_lat1", {63'b0, stall_a}, {63'b0, e.s0});
         check("stall_lat3", {63'b0, stall_b}, {63'b0, e.s1});
         check("count_lat1", {32'b0, cnt_a}, {32'b0, e.c0});
         check("count_lat3", {32'b0, cnt_b}, {32'b0, e.c1});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] ops [10];
      ops = '{OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_LUI, OP_AUIPC, OP_BR, OP_JALR, OP_JAL, OP_SYS};
      model_reset();

      step(1'b0, OP_LUI, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, OP_LUI, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // load rd=5 then a dependent add held in ID until both instances issue it
      go(OP_LOAD, 5'd0, 5'd0, 5'd5);
      repeat (4) go(OP_OP, 5'd5, 5'd0, 5'd6);
      @(negedge clk); #1;
      check("load_use_count_lat1", {32'b0, cnt_a}, 64'd1);
      check("load_use_count_lat3", {32'b0, cnt_b}, 64'd3);

      // store reading the load result through rs2; lui after a load never stalls
      go(OP_LOAD, 5'd0, 5'd0, 5'd7);
      repeat (4) go(OP_STORE, 5'd0, 5'd7, 5'd0);
      go(OP_LOAD, 5'd0, 5'd0, 5'd7);
      go(OP_LUI, 5'd7, 5'd7, 5'd3);
      repeat (3) step(1'b0, OP_LUI, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // younger addi supersedes the load; x0 is never pending
      go(OP_LOAD, 5'd0, 5'd0, 5'd9);
      go(OP_IMM, 5'd0, 5'd0, 5'd9);
      go(OP_OP, 5'd9, 5'd0, 5'd10);
      go(OP_LOAD, 5'd0, 5'd0, 5'd0);
      go(OP_OP, 5'd0, 5'd0, 5'd11);
      go(OP_SYS, 5'd0, 5'd0, 5'd11);

      // div rd=12 with a dependent add, done ten cycles after issue
      step(1'b1, OP_OP, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (9) go(OP_OP, 5'd0, 5'd12, 5'd13);
      step(1'b1, OP_OP, 1'b0, 5'd0, 5'd12, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0);
      go(OP_OP, 5'd0, 5'd12, 5'd13);

      // second MDU op while one is outstanding
      step(1'b1, OP_OP, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b1, OP_OP, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, OP_OP, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, OP_OP, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, OP_LUI, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // flush beats a pending dependency
      go(OP_LOAD, 5'd0, 5'd0, 5'd5);
      step(1'b1, OP_OP, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      go(OP_OP, 5'd5, 5'd0, 5'd6);
      repeat (3) go(OP_OP, 5'd5, 5'd0, 5'd6);

      // asynchronous reset in the middle of a stall
      go(OP_LOAD, 5'd0, 5'd0, 5'd14);
      go(OP_OP, 5'd14, 5'd0, 5'd15);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check("async_rst_stall_lat1", {63'b0, stall_a}, 64'd0);
      check("async_rst_stall_lat3", {63'b0, stall_b}, 64'd0);
      check("async_rst_count_lat1", {32'b0, cnt_a}, 64'd0);
      check("async_rst_count_lat3", {32'b0, cnt_b}, 64'd0);
      model_reset();
      go(OP_OP, 5'd14, 5'd0, 5'd15);

      for (int i = 0; i < 3000; i++) begin
         logic [4:0] op;
         bit v, mdu, fl, done, r;
         op   = ops[$urandom_range(0, 9)];
         v    = ($urandom_range(0, 7) != 0);
         mdu  = (op == OP_OP) && ($urandom_range(0, 3) == 0);
         fl   = ($urandom_range(0, 7) == 0);
         done = !(v && mdu) && ($urandom_range(0, 5) == 0);
         r    = ($urandom_range(0, 499) == 0);
         step(v, op, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), mdu, fl, done, r);
      end

      @(negedge clk); #1;
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
